// File: rtl/datapath_arbiter_if.sv
// Requester/controller bundle for datapath_arbiter: request side, shared operand bus and grant/completion flags.
// master drives requests and controller valid; slave is the arbiter itself.
interface datapath_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           dp_valid;
  logic           dp_start;
  logic [W-1:0]   dp_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [N-1:0]   err;
  logic           busy;

  modport master (
    output req, req_data, dp_valid,
    input  dp_start, dp_data, gnt, done, err, busy
  );

  modport slave (
    input  req, req_data, dp_valid,
    output dp_start, dp_data, gnt, done, err, busy
  );
endinterface

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing one start/valid datapath controller among N requesters.
// Grants one requester at a time, issues a single start, and returns done or a timeout err.
module datapath_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  rst_n,
  datapath_arbiter_if.slave     bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [CW-1:0] cnt;
  logic          sel_valid;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] ptr_next;

  // First requester at or above ptr, wrapping around modulo N.
  always_comb begin
    int k;
    k         = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      if (!sel_valid && bus.req[k]) begin
        sel_valid = 1'b1;
        sel_idx   = PW'(k);
      end
    end
  end

  assign ptr_next = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

  // Combinational steering so per-capture operand updates pass straight through.
  always_comb begin
    bus.dp_data = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) bus.dp_data = bus.req_data[i*W +: W];
    end
  end

  // A valid arriving on the final BUSY cycle takes priority over the timeout.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      gidx         <= '0;
      cnt          <= '0;
      bus.gnt      <= '0;
      bus.done     <= '0;
      bus.err      <= '0;
      bus.dp_start <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.done     <= '0;
      bus.err      <= '0;
      bus.dp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            bus.gnt      <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
            gidx         <= sel_idx;
            bus.dp_start <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.dp_valid) begin
            bus.done <= bus.gnt;
            ptr      <= ptr_next;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.err  <= bus.gnt;
            ptr      <= ptr_next;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: single op, round-robin order, wrap, timeout,
// valid/timeout collision, spurious valid and asynchronous reset mid-operation.
module tb_datapath_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 15;

  logic clock;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  datapath_arbiter_if #(.N(N), .W(W)) bus ();

  datapath_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic v);
    bus.req      = r;
    bus.req_data = d;
    bus.dp_valid = v;
  endtask

  // Called at the falling edge of an IDLE cycle whose inputs request a grant.
  // validCycle counts from the ISSUE cycle (1); 0 means the controller never answers.
  task automatic runGrant(input string tag, input logic [N-1:0] expGnt, input logic [W-1:0] expData,
                          input int validCycle, input bit dropReq);
    int  last;
    bit  timedOut;
    last     = (validCycle > 0) ? validCycle : TIMEOUT + 1;
    timedOut = (validCycle == 0);
    tick();
    checkOutput({tag, " issue gnt"},   32'(bus.gnt), 32'(expGnt));
    checkOutput({tag, " issue start"}, 32'(bus.dp_start), 32'd1);
    checkOutput({tag, " issue busy"},  32'(bus.busy), 32'd1);
    checkOutput({tag, " issue data"},  32'(bus.dp_data), 32'(expData));
    checkOutput({tag, " issue done/err"}, 32'({bus.done, bus.err}), 32'd0);
    for (int c = 2; c <= last; c++) begin
      tick();
      bus.dp_valid = (c == validCycle);
      if (dropReq && c == 2) bus.req = '0;
      checkOutput({tag, " busy start"}, 32'(bus.dp_start), 32'd0);
      checkOutput({tag, " busy gnt"},   32'(bus.gnt), 32'(expGnt));
      checkOutput({tag, " busy flag"},  32'(bus.busy), 32'd1);
      checkOutput({tag, " busy data"},  32'(bus.dp_data), 32'(expData));
      checkOutput({tag, " busy done/err"}, 32'({bus.done, bus.err}), 32'd0);
    end
    tick();
    bus.dp_valid = 1'b0;
    checkOutput({tag, " end done"},  32'(bus.done), timedOut ? 32'd0 : 32'(expGnt));
    checkOutput({tag, " end err"},   32'(bus.err), timedOut ? 32'(expGnt) : 32'd0);
    checkOutput({tag, " end gnt"},   32'(bus.gnt), 32'd0);
    checkOutput({tag, " end busy"},  32'(bus.busy), 32'd0);
    checkOutput({tag, " end start"}, 32'(bus.dp_start), 32'd0);
    checkOutput({tag, " end data"},  32'(bus.dp_data), 32'd0);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " gnt"},      32'(bus.gnt), 32'd0);
    checkOutput({tag, " done/err"}, 32'({bus.done, bus.err}), 32'd0);
    checkOutput({tag, " start"},    32'(bus.dp_start), 32'd0);
    checkOutput({tag, " busy"},     32'(bus.busy), 32'd0);
    checkOutput({tag, " data"},     32'(bus.dp_data), 32'd0);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [N*W-1:0] DATA4 = {8'h44, 8'h33, 8'h22, 8'h11};

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    applyStimulus('0, '0, 1'b0);
    tick();
    tick();
    checkQuiet("reset");
    rst_n = 1'b1;
    tick();

    // Single request, requester released after grant still completes.
    applyStimulus(4'b0001, {24'h0, 8'hA5}, 1'b0);
    runGrant("single", 4'b0001, 8'hA5, 5, 1'b1);
    tick();
    checkQuiet("single after");

    // Fresh pointer, all four requesting: order 0,1,2,3,0.
    pulseReset();
    tick();
    applyStimulus(4'b1111, DATA4, 1'b0);
    runGrant("rr0", 4'b0001, 8'h11, 5, 1'b0);
    runGrant("rr1", 4'b0010, 8'h22, 5, 1'b0);
    runGrant("rr2", 4'b0100, 8'h33, 5, 1'b0);
    runGrant("rr3", 4'b1000, 8'h44, 5, 1'b0);
    runGrant("rr4", 4'b0001, 8'h11, 5, 1'b0);

    // Pointer at 1: grant 3, then with 1001 pointer wraps to 0, then 3.
    bus.req = 4'b1000;
    runGrant("wrap3", 4'b1000, 8'h44, 5, 1'b0);
    bus.req = 4'b1001;
    runGrant("wrap0", 4'b0001, 8'h11, 5, 1'b0);
    runGrant("wrap3b", 4'b1000, 8'h44, 5, 1'b0);

    // Pointer at 0: requester 2 times out, pointer moves to 3.
    bus.req = 4'b0100;
    runGrant("timeout", 4'b0100, 8'h33, 0, 1'b0);
    bus.req = 4'b1111;
    runGrant("collide", 4'b1000, 8'h44, TIMEOUT + 1, 1'b0);

    // Spurious valid in IDLE, then held into ISSUE of the next grant.
    applyStimulus('0, DATA4, 1'b1);
    tick();
    checkQuiet("spurious idle 1");
    tick();
    checkQuiet("spurious idle 2");
    bus.req = 4'b0010;
    runGrant("spurious issue", 4'b0010, 8'h22, 5, 1'b0);

    // Pointer at 2: grant 1, then reset mid-BUSY; afterwards 1010 must pick 1.
    tick();
    tick();
    tick();
    checkOutput("pre-reset gnt", 32'(bus.gnt), 32'h2);
    checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkQuiet("async reset");
    tick();
    checkQuiet("held reset");
    rst_n   = 1'b1;
    bus.req = 4'b1010;
    runGrant("post reset", 4'b0010, 8'h22, 5, 1'b0);
    bus.req = '0;
    tick();
    checkQuiet("final idle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
